// File: rtl/add12_pkg.sv
// add12_pkg: shared sizing and FSM state type for the serial slice adder.
// Holds WIDTH/SLICE defaults, derived slice count N and the state enum.
package add12_pkg;

    localparam int WIDTH = 12;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    // SLk is encoded as ST_SLICE plus the slice index register.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLICE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cla4.sv
// cla4: carry-lookahead slice adder, W bits per call (4 by default).
// Ports: i_a, i_b operands, i_c carry in; o_s sum, o_c carry out.
module cla4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_s,
    output logic         o_c
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;
    logic         w_t;
    logic         w_pp;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is the flat sum-of-products of generates and
    // propagates below it, so no carry depends on another carry.
    always_comb begin
        w_c    = '0;
        w_t    = 1'b0;
        w_pp   = 1'b0;
        w_c[0] = i_c;
        for (int i = 0; i < W; i++) begin
            w_t  = w_g[i];
            w_pp = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_t  = w_t | (w_pp & w_g[j]);
                w_pp = w_pp & w_p[j];
            end
            w_c[i+1] = w_t | (w_pp & i_c);
        end
    end

    assign o_s = w_p ^ w_c[W-1:0];
    assign o_c = w_c[W];

endmodule

// File: rtl/add12_seq.sv
// add12_seq: multi-cycle add/sub, one SLICE-bit cla4 slice per cycle.
// Ports: clk, rst_n (sync, low), start/op/a/b in; busy/done/result/cout/ovf out.
module add12_seq
    import add12_pkg::*;
#(
    parameter int WIDTH = add12_pkg::WIDTH,
    parameter int SLICE = add12_pkg::SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_sum;
    logic             w_co;

    // Slice index drives the operand mux; latches never shift.
    assign w_a_sl = r_a[r_idx*SLICE +: SLICE];
    assign w_b_sl = r_b[r_idx*SLICE +: SLICE];

    cla4 #(
        .W(SLICE)
    ) u_cla (
        .i_a(w_a_sl),
        .i_b(w_b_sl),
        .i_c(r_c),
        .o_s(w_sum),
        .o_c(w_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b, carry-in 1.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op}};
                        r_c     <= op;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SLICE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SLICE: begin
                    r_res[r_idx*SLICE +: SLICE] <= w_sum;
                    r_c <= w_co;
                    if (r_idx == LAST) begin
                        // Top slice: its sum MSB is the result MSB.
                        r_cout  <= w_co;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_res;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_add12_seq.sv
// tb_add12_seq: directed and random checks of add12_seq
// against an integer arithmetic reference model.
module tb_add12_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [11:0] a;
    logic [11:0] b;
    logic        busy;
    logic        done;
    logic [11:0] result;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    add12_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .cout(cout),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, result} from plain signed/unsigned arithmetic.
    function automatic logic [13:0] ref_op(input logic o,
                                           input logic [11:0] x,
                                           input logic [11:0] y);
        int ux, uy, sx, sy, s, sv;
        logic c, v;
        logic [11:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 2048) ? ux - 4096 : ux;
        sy = (uy >= 2048) ? uy - 4096 : uy;
        if (!o) begin
            s  = ux + uy;
            c  = (s >= 4096);
            sv = sx + sy;
        end else begin
            s  = ux - uy + 4096;
            c  = (ux >= uy);
            sv = sx - sy;
        end
        r = 12'(s & 4095);
        v = (sv > 2047) || (sv < -2048);
        return {v, c, r};
    endfunction

    // Caller sits at a negedge; start is driven for one edge.
    task automatic do_op(input string tag, input logic o,
                         input logic [11:0] x, input logic [11:0] y);
        logic [13:0] e;
        int n;
        e = ref_op(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = $urandom;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, 3);
        chk({tag, ".res"}, 32'(result), 32'(e[11:0]));
        chk({tag, ".cout"}, 32'(cout), 32'(e[12]));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e[13]));
        chk({tag, ".busy0"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [13:0] e;
        logic [13:0] q[$];
        int ndone, last, cyc;
        logic [11:0] xa, xb;
        logic xo;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.res", 32'(result), 0);
        chk("rst.flags", {30'd0, cout, ovf}, 0);

        // Start in the first cycle out of reset must be accepted.
        rst_n = 1'b1;
        do_op("add_0ff", 1'b0, 12'h0FF, 12'h001);
        do_op("add_fff", 1'b0, 12'hFFF, 12'h001);
        do_op("add_7ff", 1'b0, 12'h7FF, 12'h001);
        do_op("sub_800", 1'b1, 12'h800, 12'h001);
        do_op("sub_000", 1'b1, 12'h000, 12'h001);
        chk("v_add7ff", 32'(ref_op(1'b0, 12'h7FF, 12'h001)), 32'h2800);

        for (int i = 0; i < 6; i++)
            do_op("rnd", 1'($urandom), 12'($urandom), 12'($urandom));

        // Start with new operands during SL1 is ignored.
        e = ref_op(1'b0, 12'h123, 12'h456);
        start = 1'b1; op = 1'b0; a = 12'h123; b = 12'h456;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b1; op = 1'b1; a = 12'hABC; b = 12'h0F0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                chk("ign.res", 32'(result), 32'(e[11:0]));
                chk("ign.flags", {30'd0, cout, ovf},
                    {30'd0, e[12], e[13]});
            end
            @(negedge clk);
        end
        chk("ign.ndone", ndone, 1);
        chk("ign.idle", 32'(busy), 0);

        // Reset while in SL1 aborts the operation.
        start = 1'b1; op = 1'b0; a = 12'h555; b = 12'h333;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.res", 32'(result), 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort.nodone", ndone, 0);

        // Start held high: a new operation every N+1 cycles.
        xo = 1'($urandom); xa = 12'($urandom); xb = 12'($urandom);
        q.push_back(ref_op(xo, xa, xb));
        start = 1'b1; op = xo; a = xa; b = xb;
        ndone = 0;
        last  = -1;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                ndone++;
                e = q.pop_front();
                chk("b2b.res", 32'(result), 32'(e[11:0]));
                chk("b2b.flags", {30'd0, cout, ovf},
                    {30'd0, e[12], e[13]});
                if (last >= 0) chk("b2b.gap", cyc - last, 4);
                last = cyc;
                xo = 1'($urandom); xa = 12'($urandom); xb = 12'($urandom);
                q.push_back(ref_op(xo, xa, xb));
                op = xo; a = xa; b = xb;
            end else if (busy) begin
                op = 1'($urandom); a = 12'($urandom); b = 12'($urandom);
            end
        end
        chk("b2b.count", ndone, 15);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
